traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 SHALL have parameter T_BASE, default 4'd6: base green interval in seconds.
REQ-002 SHALL have parameter T_EXT, default 4'd3: green extension and walk interval in seconds.
REQ-003 SHALL have parameter T_YEL, default 4'd2: yellow interval in seconds.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_Sync, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port sensor, input, 1 bit: side-street vehicle present, level.
REQ-007 SHALL have port walk_request, input, 1 bit: pedestrian button, may be a single-cycle pulse.
REQ-008 SHALL have port expired, input, 1 bit: Timer interval elapsed.
REQ-009 SHALL have port start_timer, output, 1 bit: one-cycle Timer start pulse.
REQ-010 SHALL have port value, output, 4 bits: interval in seconds sent to the Timer.
REQ-011 SHALL have port main_light, output, 3 bits: main-street lamp as {red, yellow, green}.
REQ-012 SHALL have port side_light, output, 3 bits: side-street lamp as {red, yellow, green}.
REQ-013 SHALL have port walk_lamp, output, 1 bit: pedestrian walk lamp.

Function
REQ-014 SHALL implement states MG, MG_EXT, MY, WALK, SG, SG_EXT, SY.
REQ-015 SHALL drive these lamps: MG/MG_EXT main=001, side=100; MY main=010, side=100; WALK main=100, side=100, walk_lamp=1; SG/SG_EXT main=100, side=001; SY main=100, side=010; walk_lamp=0 in all states except WALK.
REQ-016 SHALL drive value per state: MG/SG = T_BASE; MG_EXT/SG_EXT/WALK = T_EXT; MY/SY = T_YEL.
REQ-017 SHALL hold value stable for the whole state residency.
REQ-018 SHALL assert start_timer for exactly one cycle, the first cycle of every state entry, including the initial MG after reset.
REQ-019 SHALL ignore expired during the start_timer cycle and the cycle after it.
REQ-020 SHALL act on expired only from the second cycle after start_timer onward, transitioning on the first rising edge where expired=1 is sampled.
REQ-021 SHALL use these transitions on a qualified expired:
- MG -> MG_EXT if sensor=1, else MY.
- MG_EXT -> MY.
- MY -> WALK if walk_pending=1, else SG.
- WALK -> SG.
- SG -> SG_EXT if sensor=1, else SY.
- SG_EXT -> SY.
- SY -> MG.
REQ-022 SHALL sample sensor only in the cycle in which expired is qualified.
REQ-023 SHALL set walk_pending on any cycle where walk_request=1.
REQ-024 SHALL clear walk_pending in the cycle of the MY -> WALK transition.
REQ-025 SHALL treat walk_request=1 in that same MY -> WALK cycle as cleared, with the clear taking priority, so no second WALK is produced.
REQ-026 SHALL treat a walk_request during WALK as pending for the next cycle.
REQ-027 SHALL never assert green on both streets in the same cycle.
REQ-028 SHALL never assert green on either street while walk_lamp=1.
REQ-029 SHALL keep expired held high across a state change from causing a double transition (covered by REQ-019).

Reset
REQ-030 SHALL, on a clock edge with Reset_Sync=0, force state=MG, walk_pending=0, start_timer=0, value=T_BASE, main=001, side=100, walk_lamp=0.
REQ-031 SHALL, in the first cycle after Reset_Sync returns to 1, assert start_timer=1 with value=T_BASE.
REQ-032 SHALL, if reset arrives mid-state (including WALK), apply REQ-030 on the next edge with no intermediate yellow.

Structure
REQ-033 SHALL place in shared package traffic_pkg: the state enumeration, the lamp codes RED=100, YEL=010, GRN=001, and default timing constants.
REQ-034 SHALL check at elaboration that T_BASE, T_EXT and T_YEL are each in 1..15.
REQ-035 SHALL implement the walk request latch as sub-module walk_req_latch, with inputs set and clear, output pending, and clear priority.
REQ-036 SHALL keep the target size at 120-400 lines of RTL.

Verification
REQ-037 SHALL cover reset then idle (sensor=0, no walk, expired modeled 6/2 s later): MG(start, value=6) -> MY(value=2) -> SG(value=6) -> SY(value=2) -> MG, each entry with one start pulse.
REQ-038 SHALL cover sensor=1 at MG expiry: MG -> MG_EXT with value=3, then MY.
REQ-039 SHALL cover a 1-cycle walk_request during SG: the following MY -> WALK with walk_lamp=1 and both lamps 100, then SG, and pending cleared.
REQ-040 SHALL cover expired held high for 3 cycles at MY expiry: exactly one transition, and the next state's start pulse with expired ignored for 2 cycles.
REQ-041 SHALL cover Reset_Sync=0 for 1 cycle while in WALK: next cycle state MG and lamps 001/100, then start_timer=1 with value=6.
REQ-042 SHALL cover an assertion check across all tests: never both greens, never green while walk_lamp=1, and start_timer never high on two consecutive cycles.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller.
package traffic_pkg;

    // Controller phases, main street first, then side street.
    typedef enum logic [2:0] {
        MG,
        MG_EXT,
        MY,
        WALK,
        SG,
        SG_EXT,
        SY
    } state_t;

    // Lamp codes as {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Default interval lengths in seconds.
    localparam logic [3:0] DEF_T_BASE = 4'd6;
    localparam logic [3:0] DEF_T_EXT  = 4'd3;
    localparam logic [3:0] DEF_T_YEL  = 4'd2;

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
    } lamps_t;

    // Lamp pattern for a phase; unused encodings fall back to all-red.
    function automatic lamps_t state_lamps(input state_t s);
        lamps_t l;
        l.main = RED;
        l.side = RED;
        l.walk = 1'b0;
        case (s)
            MG, MG_EXT: l.main = GRN;
            MY:         l.main = YEL;
            WALK:       l.walk = 1'b1;
            SG, SG_EXT: l.side = GRN;
            SY:         l.side = YEL;
            default:    l.walk = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/walk_req_latch.sv
// Pedestrian request latch: remembers a button press until served.
module walk_req_latch (
    input  logic clk,
    input  logic Reset_Sync,
    input  logic set,
    input  logic clear,
    output logic pending
);

    // Clear wins over a simultaneous set so a press during service is dropped.
    always_ff @(posedge clk) begin
        if (!Reset_Sync) begin
            pending <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (set) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Traffic light controller driving lamps and an external interval timer.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned T_BASE = DEF_T_BASE,
    parameter int unsigned T_EXT  = DEF_T_EXT,
    parameter int unsigned T_YEL  = DEF_T_YEL
) (
    input  logic       clk,
    input  logic       Reset_Sync,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] value,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_lamp
);

    if (T_BASE == 0 || T_BASE > 15) begin : g_bad_t_base
        $error("T_BASE must be in 1..15");
    end
    if (T_EXT == 0 || T_EXT > 15) begin : g_bad_t_ext
        $error("T_EXT must be in 1..15");
    end
    if (T_YEL == 0 || T_YEL > 15) begin : g_bad_t_yel
        $error("T_YEL must be in 1..15");
    end

    localparam logic [3:0] V_BASE = 4'(T_BASE);
    localparam logic [3:0] V_EXT  = 4'(T_EXT);
    localparam logic [3:0] V_YEL  = 4'(T_YEL);

    state_t state_q;
    state_t next_state;
    logic   start_q;
    logic   start_d_q;
    logic   boot_q;
    logic   qualified;
    logic   walk_clear;
    logic   walk_pending;
    lamps_t lamps;

    walk_req_latch u_walk_req_latch (
        .clk        (clk),
        .Reset_Sync (Reset_Sync),
        .set        (walk_request),
        .clear      (walk_clear),
        .pending    (walk_pending)
    );

    // State register plus start pulse and its one-cycle shadow.
    // boot_q marks the cycle after reset so the initial MG gets its own start pulse.
    always_ff @(posedge clk) begin
        if (!Reset_Sync) begin
            state_q   <= MG;
            start_q   <= 1'b0;
            start_d_q <= 1'b0;
            boot_q    <= 1'b1;
        end else begin
            state_q   <= next_state;
            start_q   <= boot_q | qualified;
            start_d_q <= start_q;
            boot_q    <= 1'b0;
        end
    end

    // Next-state selection on a qualified timer expiry.
    always_comb begin
        next_state = state_q;
        walk_clear = 1'b0;
        qualified  = expired & ~boot_q & ~start_q & ~start_d_q;
        if (qualified) begin
            case (state_q)
                MG:      next_state = sensor ? MG_EXT : MY;
                MG_EXT:  next_state = MY;
                MY: begin
                    if (walk_pending) begin
                        next_state = WALK;
                        walk_clear = 1'b1;
                    end else begin
                        next_state = SG;
                    end
                end
                WALK:    next_state = SG;
                SG:      next_state = sensor ? SG_EXT : SY;
                SG_EXT:  next_state = SY;
                SY:      next_state = MG;
                default: next_state = MG;
            endcase
        end
    end

    // Moore outputs: lamps and timer interval depend only on the current phase.
    always_comb begin
        lamps = state_lamps(state_q);
        value = V_BASE;
        case (state_q)
            MG, SG:               value = V_BASE;
            MG_EXT, SG_EXT, WALK: value = V_EXT;
            MY, SY:               value = V_YEL;
            default:              value = V_BASE;
        endcase
    end

    assign start_timer = start_q;
    assign main_light  = lamps.main;
    assign side_light  = lamps.side;
    assign walk_lamp   = lamps.walk;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomized bench for traffic_light_fsm against a phase/age reference model.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       Reset_Sync;
    logic       sensor;
    logic       walk_request;
    logic       expired;
    logic       start_timer;
    logic [3:0] value;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;

    always #5 clk = ~clk;

    traffic_light_fsm #(
        .T_BASE (6),
        .T_EXT  (3),
        .T_YEL  (2)
    ) dut (
        .clk          (clk),
        .Reset_Sync   (Reset_Sync),
        .sensor       (sensor),
        .walk_request (walk_request),
        .expired      (expired),
        .start_timer  (start_timer),
        .value        (value),
        .main_light   (main_light),
        .side_light   (side_light),
        .walk_lamp    (walk_lamp)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Phase order: 0 MG, 1 MG_EXT, 2 MY, 3 WALK, 4 SG, 5 SG_EXT, 6 SY.
    int main_tab [7] = '{1, 1, 2, 4, 4, 4, 4};
    int side_tab [7] = '{4, 4, 4, 4, 1, 1, 2};
    int val_tab  [7] = '{6, 3, 2, 3, 6, 3, 2};

    int m_st    = 0;
    int m_age   = -1;   // cycles since the start pulse; -1 = waiting after reset
    bit m_pend  = 0;
    bit m_valid = 0;
    bit prev_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int next_of(input int s, input bit sns);
        case (s)
            0:       return sns ? 1 : 2;
            1:       return 2;
            2:       return 4;
            3:       return 4;
            4:       return sns ? 5 : 6;
            5:       return 6;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit sns, input bit wr, input bit ex);
        bit qual;
        if (!rst) begin
            m_st    = 0;
            m_pend  = 0;
            m_age   = -1;
            m_valid = 1;
        end else if (m_valid) begin
            qual = ex && (m_age >= 2);
            if (qual) begin
                if (m_st == 2 && m_pend) begin
                    m_st   = 3;
                    m_pend = 0;
                end else begin
                    m_st   = next_of(m_st, sns);
                    m_pend = m_pend | wr;
                end
                m_age = 0;
            end else begin
                m_pend = m_pend | wr;
                if (m_age < 1000) m_age++;
            end
        end
    endtask

    task automatic compare_all();
        if (m_valid) begin
            check("start_timer", 32'(start_timer), 32'(m_age == 0));
            check("value", 32'(value), val_tab[m_st]);
            check("main_light", 32'(main_light), main_tab[m_st]);
            check("side_light", 32'(side_light), side_tab[m_st]);
            check("walk_lamp", 32'(walk_lamp), 32'(m_st == 3));
            check("both_green", 32'(main_light[0] & side_light[0]), 0);
            check("green_in_walk", 32'(walk_lamp & (main_light[0] | side_light[0])), 0);
            check("start_twice", 32'(prev_start & start_timer), 0);
            prev_start = start_timer;
        end
    endtask

    task automatic step(input bit rst, input bit sns, input bit wr, input bit ex);
        Reset_Sync   = rst;
        sensor       = sns;
        walk_request = wr;
        expired      = ex;
        @(posedge clk);
        model_edge(rst, sns, wr, ex);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int hold;
        bit ex;
        Reset_Sync   = 1'b0;
        sensor       = 1'b0;
        walk_request = 1'b0;
        expired      = 1'b0;

        // Reset state.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("lit_rst_start", 32'(start_timer), 0);
        check("lit_rst_value", 32'(value), 6);
        check("lit_rst_main", 32'(main_light), 1);
        check("lit_rst_side", 32'(side_light), 4);

        // Initial MG start pulse; expired held high is ignored for two cycles.
        step(1, 0, 0, 1);
        check("lit_boot_start", 32'(start_timer), 1);
        check("lit_boot_value", 32'(value), 6);
        step(1, 0, 0, 1);
        check("lit_mg_hold_start", 32'(start_timer), 0);
        step(1, 0, 0, 1);
        check("lit_mg_still", 32'(main_light), 1);
        step(1, 1, 0, 1);
        check("lit_ext_value", 32'(value), 3);
        check("lit_ext_start", 32'(start_timer), 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        check("lit_my_main", 32'(main_light), 2);
        check("lit_my_value", 32'(value), 2);

        // Walk press while in MY, expired held high through the ignore window.
        step(1, 0, 1, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check("lit_walk_lamp", 32'(walk_lamp), 1);
        check("lit_walk_main", 32'(main_light), 4);
        check("lit_walk_side", 32'(side_light), 4);
        check("lit_walk_value", 32'(value), 3);
        step(1, 0, 0, 1);
        check("lit_walk_hold", 32'(walk_lamp), 1);
        check("lit_walk_nostart", 32'(start_timer), 0);

        // Reset while in WALK goes straight to MG.
        step(0, 0, 0, 0);
        check("lit_wrst_main", 32'(main_light), 1);
        check("lit_wrst_side", 32'(side_light), 4);
        check("lit_wrst_walk", 32'(walk_lamp), 0);
        step(1, 0, 0, 0);
        check("lit_wrst_start", 32'(start_timer), 1);
        check("lit_wrst_value", 32'(value), 6);

        // Randomized traffic with bursts of held expiry and rare resets.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold > 0) begin
                ex = 1'b1;
                hold--;
            end else begin
                ex = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 9) == 0) hold = $urandom_range(1, 4);
            end
            step(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), ex);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
